// File: rtl/ppe_pkg.sv
// ppe_pkg: packet layout, opcodes and sequencer states shared by the PPE stream controller
package ppe_pkg;
    localparam int ADDR_START   = 32;
    localparam int ADDR_END     = 29;
    localparam int OPCODE_START = 28;
    localparam int OPCODE_END   = 25;
    localparam int DATA_START   = 24;
    localparam int DATA_END     = 0;
    localparam int PKT_W        = 33;
    localparam logic [3:0] OP_WEIGHT   = 4'd0;
    localparam logic [3:0] OP_INPUT    = 4'd1;
    localparam logic [3:0] OP_TIMESTEP = 4'd15;
    typedef enum logic [3:0] {
        IDLE, W_FETCH, W_LATCH, W_SEND, I_FETCH, I_LATCH, I_SEND, T_SEND, FINISH
    } seq_state_t;
    function automatic logic [PKT_W-1:0] make_pkt(input logic [3:0] addr, input logic [3:0] opcode,
                                                  input logic [24:0] data);
        logic [PKT_W-1:0] p;
        p = '0;
        p[ADDR_START:ADDR_END]     = addr;
        p[OPCODE_START:OPCODE_END] = opcode;
        p[DATA_START:DATA_END]     = data;
        return p;
    endfunction
endpackage

// File: rtl/ppe_sequencer.sv
// ppe_sequencer: streams weights, then per-timestep spike rows and a timestep marker, into one PPE
module ppe_sequencer
    import ppe_pkg::*;
#(
    parameter int PE_ADDR         = 5,
    parameter int NUM_WEIGHT_PKTS = 2,
    parameter int ROWS_PER_TS     = 5,
    parameter int NUM_TS          = 2,
    parameter int W_AW            = 4,
    parameter int IF_AW           = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        w_rd_en,
    output logic [W_AW-1:0]             w_rd_addr,
    input  logic [23:0]                 w_rd_data,
    output logic                        if_rd_en,
    output logic [IF_AW-1:0]            if_rd_addr,
    input  logic [24:0]                 if_rd_data,
    output logic                        pkt_valid,
    input  logic                        pkt_ready,
    output logic [PKT_W-1:0]            pkt_data,
    output logic [$clog2(NUM_TS+1)-1:0] ts_idx
);
    localparam int TW = $clog2(NUM_TS+1);
    localparam int RW = $clog2(ROWS_PER_TS+1);
    seq_state_t state, state_nx;
    logic [RW-1:0] row;
    logic xfer, last_w, last_row;
    assign xfer     = pkt_valid && pkt_ready;
    assign last_w   = w_rd_addr == W_AW'(NUM_WEIGHT_PKTS-1);
    assign last_row = row == RW'(ROWS_PER_TS-1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx  = state;
        busy      = state != IDLE && state != FINISH;
        done      = state == FINISH;
        w_rd_en   = state == W_FETCH;
        if_rd_en  = state == I_FETCH;
        pkt_valid = state == W_SEND || state == I_SEND || state == T_SEND;
        case (state)
            IDLE:    state_nx = start ? W_FETCH : IDLE;
            W_FETCH: state_nx = W_LATCH;
            W_LATCH: state_nx = W_SEND;
            W_SEND:  state_nx = xfer ? (last_w ? I_FETCH : W_FETCH) : W_SEND;
            I_FETCH: state_nx = I_LATCH;
            I_LATCH: state_nx = I_SEND;
            I_SEND:  state_nx = xfer ? (last_row ? T_SEND : I_FETCH) : I_SEND;
            T_SEND:  state_nx = xfer ? (ts_idx == TW'(NUM_TS-1) ? FINISH : I_FETCH) : T_SEND;
            default: state_nx = IDLE;
        endcase
    end
    // the timestep packet is loaded on the handshake of the last row so it is ready on entry to T_SEND
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_rd_addr  <= '0;
            if_rd_addr <= '0;
            row        <= '0;
            ts_idx     <= '0;
            pkt_data   <= '0;
        end else begin
            if (state == IDLE && start) begin
                w_rd_addr  <= '0;
                if_rd_addr <= '0;
                row        <= '0;
                ts_idx     <= '0;
            end
            if (state == W_SEND && xfer && !last_w) w_rd_addr <= w_rd_addr + 1'b1;
            if (state == I_SEND && xfer) begin
                if_rd_addr <= if_rd_addr + 1'b1;
                row        <= last_row ? '0 : row + 1'b1;
            end
            if (state == T_SEND && xfer) ts_idx <= ts_idx + 1'b1;
            if (state == W_LATCH)
                pkt_data <= make_pkt(4'(PE_ADDR), OP_WEIGHT,
                                     {1'b0, w_rd_data[23:16] & {8{!last_w}}, w_rd_data[15:0]});
            if (state == I_LATCH) pkt_data <= make_pkt(4'(PE_ADDR), OP_INPUT, if_rd_data);
            if (state == I_SEND && xfer && last_row) pkt_data <= make_pkt(4'(PE_ADDR), OP_TIMESTEP, '0);
        end
    end
endmodule

// File: tb/tb_ppe_sequencer.sv
// tb_ppe_sequencer: directed checks of packet order, latency, backpressure, mid-run start/reset, minimal config
module tb_ppe_sequencer;
    logic clk = 0, reset = 1, start = 0, pkt_ready = 1, start_s = 0;
    always #5 clk = ~clk;
    logic busy, done, w_rd_en, if_rd_en, pkt_valid;
    logic [3:0] w_rd_addr;
    logic [5:0] if_rd_addr;
    logic [23:0] w_rd_data;
    logic [24:0] if_rd_data;
    logic [32:0] pkt_data;
    logic [1:0] ts_idx;
    logic busy_s, done_s, w_rd_en_s, if_rd_en_s, pkt_valid_s;
    logic [3:0] w_rd_addr_s;
    logic [5:0] if_rd_addr_s;
    logic [23:0] w_rd_data_s;
    logic [24:0] if_rd_data_s;
    logic [32:0] pkt_data_s;
    logic [0:0] ts_idx_s;
    logic [23:0] wmem [16];
    logic [24:0] ifmem [64];
    logic [32:0] q[$], qs[$], held;
    logic [32:0] exp_d [14] = '{33'h0A0030201, 33'h0A0000504,
        33'h0A2AAAAAA, 33'h0A3555555, 33'h0A2AAAAAA, 33'h0A3555555, 33'h0A2AAAAAA, 33'h0BE000000,
        33'h0A3555555, 33'h0A2AAAAAA, 33'h0A3555555, 33'h0A2AAAAAA, 33'h0A3555555, 33'h0BE000000};
    int cyc = 0, s0 = 0, s0s = 0, first_v = -1, done_cnt = 0, done_at = -1, done_at_s = -1;
    int stall = 0, stall_rd = 0, n_chk = 0, n_fail = 0;

    ppe_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .if_rd_en(if_rd_en), .if_rd_addr(if_rd_addr), .if_rd_data(if_rd_data),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data), .ts_idx(ts_idx));

    ppe_sequencer #(.NUM_WEIGHT_PKTS(1), .ROWS_PER_TS(1), .NUM_TS(1)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s),
        .w_rd_en(w_rd_en_s), .w_rd_addr(w_rd_addr_s), .w_rd_data(w_rd_data_s),
        .if_rd_en(if_rd_en_s), .if_rd_addr(if_rd_addr_s), .if_rd_data(if_rd_data_s),
        .pkt_valid(pkt_valid_s), .pkt_ready(1'b1), .pkt_data(pkt_data_s), .ts_idx(ts_idx_s));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
        if (if_rd_en) if_rd_data <= ifmem[if_rd_addr];
        if (w_rd_en_s) w_rd_data_s <= wmem[w_rd_addr_s];
        if (if_rd_en_s) if_rd_data_s <= ifmem[if_rd_addr_s];
    end

    always @(negedge clk) begin
        if (pkt_valid && pkt_ready) q.push_back(pkt_data);
        if (pkt_valid_s) qs.push_back(pkt_data_s);
        if (pkt_valid && first_v < 0) first_v = cyc - s0;
        if (done) begin done_cnt++; done_at = cyc - s0; end
        if (done_s) done_at_s = cyc - s0s;
        if (stall != 0 && if_rd_en) stall_rd++;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic go;
        start = 1;
        s0 = cyc;
        first_v = -1;
        step;
        start = 0;
    endtask

    task automatic wait_done(input int limit);
        int n0 = done_cnt;
        for (int i = 0; i < limit && done_cnt == n0; i++) step;
        chk("run_completes", 64'(done_cnt != n0), 64'd1);
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_count"}, 64'(q.size()), 64'd14);
        for (int i = 0; i < 14; i++)
            chk($sformatf("%s_pkt%0d", tag, i), i < q.size() ? 64'(q[i]) : 64'hdead, 64'(exp_d[i]));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) wmem[i] = 24'hFFFFFF;
        wmem[0] = 24'h030201;
        wmem[1] = 24'h000504;
        for (int i = 0; i < 64; i++) ifmem[i] = (i % 2 == 1) ? 25'h1555555 : 25'h0AAAAAA;
        step;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'({w_rd_en, if_rd_en}), 64'd0);
        chk("rst_valid", 64'(pkt_valid), 64'd0);
        chk("rst_data", 64'(pkt_data), 64'd0);
        chk("rst_addrs", 64'({w_rd_addr, if_rd_addr}), 64'd0);
        chk("rst_ts", 64'(ts_idx), 64'd0);
        step;
        reset = 0;
        step;
        // nominal run with a redundant start in cycle 8
        q.delete();
        done_cnt = 0;
        go;
        chk("c1_busy", 64'(busy), 64'd1);
        chk("c1_w_rd", 64'({w_rd_en, w_rd_addr}), 64'h10);
        repeat (7) step;
        start = 1;
        step;
        start = 0;
        wait_done(100);
        chk("first_valid_cycle", 64'(first_v), 64'd3);
        chk("done_cycle", 64'(done_at), 64'd39);
        chk_stream("nominal");
        chk("end_ts_idx", 64'(ts_idx), 64'd2);
        chk("end_done_low", 64'({done, busy}), 64'd0);
        repeat (5) step;
        chk("single_done", 64'(done_cnt), 64'd1);
        chk("idle_after", 64'({busy, pkt_valid}), 64'd0);
        // backpressure on the third input packet
        q.delete();
        done_cnt = 0;
        go;
        for (int i = 0; i < 60 && !(q.size() == 4 && pkt_valid); i++) step;
        chk("bp_reached", 64'(pkt_valid), 64'd1);
        pkt_ready = 0;
        held = pkt_data;
        stall = 1;
        chk("bp_pkt", 64'(held), 64'(exp_d[4]));
        for (int i = 0; i < 10; i++) begin
            step;
            chk("bp_valid", 64'(pkt_valid), 64'd1);
            chk("bp_data", 64'(pkt_data), 64'(held));
        end
        pkt_ready = 1;
        stall = 0;
        wait_done(100);
        chk("bp_no_read", 64'(stall_rd), 64'd0);
        chk_stream("bp");
        chk("bp_done_cnt", 64'(done_cnt), 64'd1);
        // asynchronous reset during an input packet of timestep 1
        q.delete();
        done_cnt = 0;
        go;
        for (int i = 0; i < 60 && !(ts_idx == 2'd1 && pkt_valid); i++) step;
        chk("rst_mid_reached", 64'({ts_idx, pkt_valid}), 64'h3);
        #2 reset = 1;
        #1;
        chk("rst_mid_valid", 64'(pkt_valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_ts", 64'(ts_idx), 64'd0);
        chk("rst_mid_data", 64'(pkt_data), 64'd0);
        step;
        step;
        reset = 0;
        repeat (3) step;
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        q.delete();
        go;
        chk("replay_w_addr", 64'({w_rd_en, w_rd_addr}), 64'h10);
        wait_done(100);
        chk("replay_done_cycle", 64'(done_at), 64'd39);
        chk_stream("replay");
        // minimal configuration instance
        qs.delete();
        start_s = 1;
        s0s = cyc;
        step;
        start_s = 0;
        for (int i = 0; i < 50 && done_at_s < 0; i++) step;
        chk("small_done_cycle", 64'(done_at_s), 64'd8);
        chk("small_count", 64'(qs.size()), 64'd3);
        chk("small_pkt0", qs.size() > 0 ? 64'(qs[0]) : 64'hdead, 64'h0A0000201);
        chk("small_pkt1", qs.size() > 1 ? 64'(qs[1]) : 64'hdead, 64'h0A2AAAAAA);
        chk("small_pkt2", qs.size() > 2 ? 64'(qs[2]) : 64'hdead, 64'h0BE000000);
        step;
        chk("small_end", 64'({ts_idx_s, busy_s, if_rd_en_s}), 64'h4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
